// File: rtl/sound_mixer_if.sv
// Game-logic-to-mixer bundle: event pulses, play length, tone settings and mute going in;
// activity flags, selected channel and speaker pin coming back.
`timescale 1ns/1ps

interface sound_mixer_if #(
    parameter int NUM_CH = 3,
    parameter int DUR_W  = 25,
    parameter int DIV_W  = 16
);
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]       event_in;
    logic [DUR_W-1:0]        dur;
    logic [NUM_CH*DIV_W-1:0] tone_half;
    logic                    mute;
    logic [NUM_CH-1:0]       active;
    logic                    busy;
    logic [SEL_W-1:0]        sel_ch;
    logic                    speaker;

    modport master (
        output event_in, dur, tone_half, mute,
        input  active, busy, sel_ch, speaker
    );

    modport slave (
        input  event_in, dur, tone_half, mute,
        output active, busy, sel_ch, speaker
    );
endinterface

// File: rtl/sound_mixer.sv
// Multi-channel event sound mixer: per-channel duration timers, fixed-priority channel
// selection and a shared square-wave tone generator driving one speaker pin.
`timescale 1ns/1ps

module sound_mixer #(
    parameter int NUM_CH    = 3,
    parameter int DUR_W     = 25,
    parameter int DIV_W     = 16,
    parameter int RETRIGGER = 1
) (
    input logic          clk,
    input logic          rst,
    sound_mixer_if.slave bus
);
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [DUR_W-1:0]  timer_q [NUM_CH];
    logic [DUR_W-1:0]  timer_d [NUM_CH];
    logic [NUM_CH-1:0] active_q, active_d;

    logic              busy;
    logic [SEL_W-1:0]  sel;
    logic              busy_prev_q;
    logic [SEL_W-1:0]  sel_prev_q;
    logic              change;

    logic [DIV_W-1:0]  half_raw, half_m1;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic              spk_q, spk_d;
    logic              restart_q, restart_d;

    // NOTE: every variable gets a default at the top of an always_comb so no path can infer a latch.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            timer_d[i] = (timer_q[i] != '0) ? timer_q[i] - DUR_W'(1) : '0;
            if (bus.event_in[i] && (bus.dur != '0) && ((RETRIGGER != 0) || (timer_q[i] == '0)))
                timer_d[i] = bus.dur;
            // active mirrors the next timer value so it rises right after the loading edge
            active_d[i] = (timer_d[i] != '0);
        end
    end

    always_comb begin
        sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (active_q[i])
                sel = SEL_W'(i);
        end
    end

    assign busy   = |active_q;
    assign change = busy && (!busy_prev_q || (sel != sel_prev_q));

    always_comb begin
        half_raw = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_W'(i))
                half_raw = bus.tone_half[i*DIV_W +: DIV_W];
        end
        // a zero half-period behaves as one, i.e. toggle every cycle
        half_m1 = (half_raw == '0) ? '0 : half_raw - DIV_W'(1);
    end

    // A start or channel switch holds the phase low for two edges before counting resumes.
    always_comb begin
        cnt_d     = cnt_q;
        spk_d     = spk_q;
        restart_d = 1'b0;
        if (!busy) begin
            cnt_d = '0;
            spk_d = 1'b0;
        end else if (change || restart_q) begin
            cnt_d     = '0;
            spk_d     = 1'b0;
            restart_d = change;
        end else if (cnt_q >= half_m1) begin
            cnt_d = '0;
            spk_d = ~spk_q;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the timer array is reset because the activity flags are derived from it.
            for (int i = 0; i < NUM_CH; i++)
                timer_q[i] <= '0;
            active_q    <= '0;
            busy_prev_q <= 1'b0;
            sel_prev_q  <= '0;
            cnt_q       <= '0;
            spk_q       <= 1'b0;
            restart_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                timer_q[i] <= timer_d[i];
            active_q    <= active_d;
            busy_prev_q <= busy;
            sel_prev_q  <= sel;
            cnt_q       <= cnt_d;
            spk_q       <= spk_d;
            restart_q   <= restart_d;
        end
    end

    assign bus.active  = active_q;
    assign bus.busy    = busy;
    assign bus.sel_ch  = sel;
    assign bus.speaker = spk_q & busy & ~change & ~bus.mute;
endmodule

// File: tb/tb_sound_mixer.sv
// Directed bench for sound_mixer: stimulus pushes per-cycle expected outputs into a
// scoreboard queue, a negedge monitor pops and compares. Two instances cover both RETRIGGER modes.
`timescale 1ns/1ps

module tb_sound_mixer;
    localparam int NUM_CH = 3;
    localparam int DUR_W  = 25;
    localparam int DIV_W  = 16;

    typedef enum int {T_RST, T_RESET_MID, T_SINGLE, T_PREEMPT, T_RETRIG, T_DUR0, T_ALL3, T_MUTE} tag_e;

    typedef struct {
        int         cyc;
        int         dut;
        tag_e       tag;
        logic [2:0] act;
        logic [1:0] sel;
        logic       spk;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [NUM_CH-1:0]       ev_in;
    logic [DUR_W-1:0]        dur;
    logic [NUM_CH*DIV_W-1:0] tone_half;
    logic                    mute;

    int   cyc        = 0;
    int   nvec       = 0;
    int   miscompares = 0;
    exp_t sb[$];
    exp_t mon_e;

    sound_mixer_if #(.NUM_CH(NUM_CH), .DUR_W(DUR_W), .DIV_W(DIV_W)) if1 ();
    sound_mixer_if #(.NUM_CH(NUM_CH), .DUR_W(DUR_W), .DIV_W(DIV_W)) if0 ();

    assign if1.event_in  = ev_in;
    assign if1.dur       = dur;
    assign if1.tone_half = tone_half;
    assign if1.mute      = mute;
    assign if0.event_in  = ev_in;
    assign if0.dur       = dur;
    assign if0.tone_half = tone_half;
    assign if0.mute      = mute;

    sound_mixer #(.NUM_CH(NUM_CH), .DUR_W(DUR_W), .DIV_W(DIV_W), .RETRIGGER(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    sound_mixer #(.NUM_CH(NUM_CH), .DUR_W(DUR_W), .DIV_W(DIV_W), .RETRIGGER(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string tag_name(tag_e t);
        case (t)
            T_RST:       return "reset_state";
            T_RESET_MID: return "reset_mid_play";
            T_SINGLE:    return "single_event";
            T_PREEMPT:   return "preemption";
            T_RETRIG:    return "retrigger";
            T_DUR0:      return "dur_zero";
            T_ALL3:      return "all3_half0";
            default:     return "mute";
        endcase
    endfunction

    // Speaker for a tone that (re)started at edge k with effective half-period h.
    function automatic logic sq(int k, int h, int c);
        if (c < k + 2)
            return 1'b0;
        return (((c - k - 2) / h) % 2) == 1;
    endfunction

    task automatic expect_at(input int c, input int d, input tag_e t,
                             input logic [2:0] a, input logic [1:0] s, input logic sp);
        exp_t e;
        e.cyc = c;
        e.dut = d;
        e.tag = t;
        e.act = a;
        e.sel = s;
        e.spk = sp;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input int c, input int d,
                         input logic [6:0] got, input logic [6:0] exp);
        nvec++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d dut_retrig=%0d got act=%b busy=%b sel=%0d spk=%b exp act=%b busy=%b sel=%0d spk=%b",
                     name, c, d, got[6:4], got[3], got[2:1], got[0], exp[6:4], exp[3], exp[2:1], exp[0]);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.cyc != cyc) begin
                nvec++;
                miscompares++;
                $display("FAIL %s expectation for cyc=%0d reached only at cyc=%0d", tag_name(mon_e.tag), mon_e.cyc, cyc);
            end else if (mon_e.dut == 1) begin
                check(tag_name(mon_e.tag), cyc, 1,
                      {if1.active, if1.busy, if1.sel_ch, if1.speaker},
                      {mon_e.act, |mon_e.act, mon_e.sel, mon_e.spk});
            end else begin
                check(tag_name(mon_e.tag), cyc, 0,
                      {if0.active, if0.busy, if0.sel_ch, if0.speaker},
                      {mon_e.act, |mon_e.act, mon_e.sel, mon_e.spk});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns k, the edge that will sample inputs driven right after this call.
    task automatic arm(output int k);
        step(1);
        k = cyc + 1;
    endtask

    initial begin
        int         k;
        int         guard;
        logic [7:0] pat;
        logic [2:0] a;
        logic [1:0] s;
        logic       sp;

        rst       = 1'b1;
        ev_in     = '0;
        dur       = '0;
        tone_half = '0;
        mute      = 1'b0;

        for (int c = 1; c <= 2; c++) begin
            expect_at(c, 1, T_RST, 3'b000, 2'd0, 1'b0);
            expect_at(c, 0, T_RST, 3'b000, 2'd0, 1'b0);
        end
        step(2);
        rst = 1'b0;

        // Reset mid-play: ch0 dur=10 half=2, rst asserted between edges k+4 and k+5.
        arm(k);
        tone_half = {16'd0, 16'd0, 16'd2};
        dur       = 25'd10;
        ev_in     = 3'b001;
        for (int c = k; c <= k + 3; c++) begin
            expect_at(c, 1, T_RESET_MID, 3'b001, 2'd0, 1'b0);
            expect_at(c, 0, T_RESET_MID, 3'b001, 2'd0, 1'b0);
        end
        for (int c = k + 4; c <= k + 9; c++) begin
            expect_at(c, 1, T_RESET_MID, 3'b000, 2'd0, 1'b0);
            expect_at(c, 0, T_RESET_MID, 3'b000, 2'd0, 1'b0);
        end
        step(1);
        ev_in = '0;
        step(4);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(4);

        // Single event: ch1 dur=8 half=2, low for 4 cycles then 2 high, 2 low.
        arm(k);
        tone_half = {16'd0, 16'd2, 16'd0};
        dur       = 25'd8;
        ev_in     = 3'b010;
        pat       = 8'b0011_0000;
        for (int o = 0; o < 8; o++)
            expect_at(k + o, 1, T_SINGLE, 3'b010, 2'd1, pat[o]);
        expect_at(k + 8, 1, T_SINGLE, 3'b000, 2'd0, 1'b0);
        expect_at(k + 9, 1, T_SINGLE, 3'b000, 2'd0, 1'b0);
        step(1);
        ev_in = '0;
        step(10);

        // Pre-emption: ch2 dur=20 half=4, ch0 dur=6 half=1 loaded at edge k+5.
        arm(k);
        tone_half = {16'd4, 16'd0, 16'd1};
        dur       = 25'd20;
        ev_in     = 3'b100;
        for (int c = k; c <= k + 21; c++) begin
            if (c <= k + 4) begin
                a = 3'b100; s = 2'd2; sp = sq(k, 4, c);
            end else if (c <= k + 10) begin
                a = 3'b101; s = 2'd0; sp = sq(k + 5, 1, c);
            end else if (c <= k + 19) begin
                a = 3'b100; s = 2'd2; sp = sq(k + 11, 4, c);
            end else begin
                a = 3'b000; s = 2'd0; sp = 1'b0;
            end
            expect_at(c, 1, T_PREEMPT, a, s, sp);
        end
        step(1);
        ev_in = '0;
        step(4);
        dur   = 25'd6;
        ev_in = 3'b001;
        step(1);
        ev_in = '0;
        step(17);

        // Retrigger: ch0 dur=5 half=3, re-pulse sampled while timer==1.
        arm(k);
        tone_half = {16'd0, 16'd0, 16'd3};
        dur       = 25'd5;
        ev_in     = 3'b001;
        for (int c = k; c <= k + 11; c++) begin
            expect_at(c, 1, T_RETRIG, (c <= k + 9) ? 3'b001 : 3'b000, 2'd0,
                      (c <= k + 9) ? sq(k, 3, c) : 1'b0);
            expect_at(c, 0, T_RETRIG, (c <= k + 4) ? 3'b001 : 3'b000, 2'd0,
                      (c <= k + 4) ? sq(k, 3, c) : 1'b0);
        end
        step(1);
        ev_in = '0;
        step(4);
        ev_in = 3'b001;
        step(1);
        ev_in = '0;
        step(7);

        // dur=0 on every channel: nothing happens.
        arm(k);
        tone_half = {16'd2, 16'd2, 16'd2};
        dur       = 25'd0;
        ev_in     = 3'b111;
        for (int c = k; c <= k + 3; c++) begin
            expect_at(c, 1, T_DUR0, 3'b000, 2'd0, 1'b0);
            expect_at(c, 0, T_DUR0, 3'b000, 2'd0, 1'b0);
        end
        step(1);
        ev_in = '0;
        step(4);

        // All three channels at once, ch0 half=0 (toggle every cycle).
        arm(k);
        tone_half = {16'd5, 16'd5, 16'd0};
        dur       = 25'd6;
        ev_in     = 3'b111;
        for (int c = k; c <= k + 7; c++) begin
            if (c <= k + 5)
                expect_at(c, 1, T_ALL3, 3'b111, 2'd0, sq(k, 1, c));
            else
                expect_at(c, 1, T_ALL3, 3'b000, 2'd0, 1'b0);
        end
        step(1);
        ev_in = '0;
        step(8);

        // Mute: ch1 dur=16 half=3, muted for cycles k+3..k+11, released inside a high phase.
        arm(k);
        tone_half = {16'd0, 16'd3, 16'd0};
        dur       = 25'd16;
        ev_in     = 3'b010;
        for (int c = k; c <= k + 17; c++) begin
            if (c <= k + 15)
                expect_at(c, 1, T_MUTE, 3'b010, 2'd1,
                          (c >= k + 3 && c <= k + 11) ? 1'b0 : sq(k, 3, c));
            else
                expect_at(c, 1, T_MUTE, 3'b000, 2'd0, 1'b0);
        end
        step(1);
        ev_in = '0;
        step(3);
        mute = 1'b1;
        step(9);
        mute = 1'b0;
        step(6);

        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            nvec++;
            miscompares++;
            $display("FAIL drain %0d expectations still pending, required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, miscompares);
        $finish;
    end
endmodule

// File: doc/sound_mixer.md
Name: sound_mixer

Overview:
- Parametrised successor to the single-shot sound latch. It accepts NUM_CH one-cycle game events (hit, wall, goal, ...), each driving its own duration timer.
- A fixed-priority selector picks the highest-priority active channel. That channel's tone divider produces a square wave on a single speaker pin.
- Sits between the game logic and the board audio pin. It also exports per-channel activity flags for LEDs and debug.

Parameters:
- NUM_CH, 3, number of event channels; channel 0 has highest priority.
- DUR_W, 25, width of the duration timers and the dur input.
- DIV_W, 16, width of each channel's tone half-period field.
- RETRIGGER, 1, 1: an event on an active channel reloads its timer; 0: such an event is ignored.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- event_in  in  NUM_CH  one-cycle event pulses, bit i = channel i.
- dur  in  DUR_W  play length in clk cycles; sampled when an event loads a timer.
- tone_half  in  NUM_CH*DIV_W  per-channel half-period in clk cycles; channel i occupies bits [i*DIV_W +: DIV_W].
- mute  in  1  forces speaker low; timers keep running.
- active  out  NUM_CH  bit i high while channel i's timer is non-zero.
- busy  out  1  OR of active.
- sel_ch  out  $clog2(NUM_CH) (min 1)  index of the selected channel; 0 when idle.
- speaker  out  1  square-wave audio output.

Behaviour:
- Reset (async): all timers 0, active=0, busy=0, sel_ch=0, tone counter 0, speaker=0.
- Timer load: event_in[i]=1 at edge k with dur!=0 loads timer[i]=dur.
  - If timer[i]!=0 and RETRIGGER=0, the load does not happen.
  - dur==0: the event is ignored on every channel.
  - active[i] rises after edge k and stays high for exactly dur cycles.
- Timer run: a non-zero timer decrements by 1 per cycle with no wrap. active[i] = (timer[i]!=0), registered.
- Reload vs expiry: an event in the cycle where timer[i]==1 reloads, provided RETRIGGER=1 or the channel is otherwise allowed to load. active[i] stays high with no gap.
- Simultaneous events: all pulsed channels load independently in the same cycle.
- Selection: sel_ch = lowest index i with active[i]=1, computed from registered active. busy = |active.
- Tone generator: one shared counter, tone_cnt, of width DIV_W.
  - While busy, tone_cnt increments each cycle.
  - When tone_cnt reaches half-1 (half = the selected channel's tone_half): speaker toggles and tone_cnt clears.
  - tone_half==0 is treated as 1, so speaker toggles every cycle.
- Channel change: when sel_ch changes, or busy goes 0->1, tone_cnt clears and speaker is driven 0 in that cycle. The new tone therefore always starts in a low phase.
- Idle: when busy=0, tone_cnt is held at 0 and speaker=0.
- Mute: speaker output = internal square & ~mute. The internal phase continues so unmute is glitch-consistent.
- Input sampling: tone_half changes mid-play take effect at the next compare. Any tone_cnt>=half-1 counts as a match and toggles, so a smaller new value cannot cause a counter overrun.
- Reset mid-play: all outputs return to reset values immediately, asynchronously.
- Latency summary:
  - event to active: 1 cycle.
  - event to first speaker toggle: 2 + half cycles after the event edge. This is one cycle of active registration, one cycle of phase reset, then the half-period count.

Test Plan:
- Reset mid-play: event_in=3'b001 with dur=10, then assert rst at cycle 4 -> active, busy and speaker go 0 immediately. After release, no activity until a new event.
- Single event: event_in=3'b010, dur=8, tone_half[1]=2 -> active=3'b010 for exactly 8 cycles, sel_ch=1. Speaker toggles every 2 cycles starting low. speaker=0 once busy drops.
- Priority pre-emption: start ch2 (dur=20, half=4); at cycle 5 pulse ch0 (dur=6, half=1) -> sel_ch 2->0 with phase reset, speaker toggles every cycle for 6 cycles. Then sel_ch returns to 2, again with phase reset and starting low, and ch2 ends at its original cycle 20.
- Retrigger: RETRIGGER=1, ch0 dur=5, re-pulse at the cycle where timer==1 -> active[0] stays high for 5 more cycles with no gap. Same stimulus with RETRIGGER=0 -> active[0] falls after 5 cycles total.
- Boundaries: dur=0 event -> no activity. tone_half=0 -> toggle every cycle. Events on all 3 channels in the same cycle -> active=3'b111, sel_ch=0.
- Mute: mute=1 during play -> speaker=0 while active and busy continue. Deassert mute mid-period -> speaker resumes at the current internal phase.
